// File: rtl/bram_manager.sv
// Tile store for the attention datapath: NUM_MAT tiles of ROWS x COLS signed bytes
// in one row-wide block RAM, moved in or out one row per clock by a small request FSM.
module bram_manager #(
    parameter int NUM_MAT = 64,
    parameter int ROWS    = 16,
    parameter int COLS    = 128,
    parameter int DW      = 8
) (
    input  logic                               I_CLK,
    input  logic                               I_RST_N,
    input  logic                               I_RD_VLD_PULSE,
    input  logic                               I_WR_VLD_PULSE,
    input  logic [7:0]                         I_SEL,
    input  logic [0:ROWS-1][0:COLS-1][DW-1:0]  I_MAT,
    output logic                               O_VLD,
    output logic [0:ROWS-1][0:COLS-1][DW-1:0]  O_MAT,
    output logic                               O_WR_DONE
);

    localparam int SEL_W  = $clog2(NUM_MAT);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int CNT_W  = ROW_W + 1;
    localparam int DEPTH  = NUM_MAT * ROWS;
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] WR_TAIL  = CNT_W'(ROWS);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        READ_DRAIN
    } state_t;

    typedef logic [0:COLS-1][DW-1:0] row_t;

    state_t                   state;
    logic [CNT_W-1:0]         cnt;
    logic [SEL_W-1:0]         sel_q;
    logic [0:ROWS-1][0:COLS-1][DW-1:0] wbuf;
    row_t                     ram_q;
    logic                     cap_vld;
    logic [ROW_W-1:0]         cap_row;

    logic                     ram_we;
    logic                     ram_re;
    logic [SEL_W+ROW_W-1:0]   ram_addr;
    logic                     wr_accept;
    logic                     rd_accept;
    logic                     unused_sel_hi;

    // Slots above NUM_MAT-1 alias onto the low index bits.
    assign unused_sel_hi = ^I_SEL[7:SEL_W];

    assign wr_accept = (state == IDLE) && I_WR_VLD_PULSE;
    assign rd_accept = (state == IDLE) && !I_WR_VLD_PULSE && I_RD_VLD_PULSE;

    // The write tail cycle (cnt == ROWS) only delays the done pulse.
    assign ram_we   = (state == WRITE) && (cnt != WR_TAIL);
    assign ram_re   = (state == READ);
    assign ram_addr = {sel_q, cnt[ROW_W-1:0]};

    // Contents come up zeroed from the configuration image.
    row_t mem [DEPTH] = '{default: '0};

    // NOTE: the RAM array and its output register carry no reset so they map onto
    // block RAM; the reset only clears the control path and O_MAT.
    always_ff @(posedge I_CLK) begin
        if (ram_we) begin
            mem[ram_addr] <= wbuf[cnt[ROW_W-1:0]];
        end
        if (ram_re) begin
            ram_q <= mem[ram_addr];
        end
    end

    // Whole tile is captured at accept so the bus is free afterwards.
    always_ff @(posedge I_CLK) begin
        if (wr_accept) begin
            wbuf <= I_MAT;
        end
    end

    // NOTE: every sequential block uses <= so all registers see pre-edge values;
    // a blocking = here would let later statements observe already-updated state.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state     <= IDLE;
            cnt       <= '0;
            sel_q     <= '0;
            O_VLD     <= 1'b0;
            O_WR_DONE <= 1'b0;
            cap_vld   <= 1'b0;
            cap_row   <= '0;
        end else begin
            O_VLD     <= 1'b0;
            O_WR_DONE <= 1'b0;
            cap_vld   <= (state == READ);
            cap_row   <= cnt[ROW_W-1:0];
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (wr_accept) begin
                        sel_q <= I_SEL[SEL_W-1:0];
                        state <= WRITE;
                    end else if (rd_accept) begin
                        sel_q <= I_SEL[SEL_W-1:0];
                        state <= READ;
                    end
                end
                WRITE: begin
                    if (cnt == WR_TAIL) begin
                        cnt       <= '0;
                        O_WR_DONE <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                READ: begin
                    if (cnt == LAST_ROW) begin
                        cnt   <= '0;
                        state <= READ_DRAIN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                READ_DRAIN: begin
                    // One cycle for the RAM output, one for the O_MAT capture.
                    if (cnt[0]) begin
                        cnt   <= '0;
                        O_VLD <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Rows land one clock after their RAM read; O_MAT otherwise holds.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            O_MAT <= '0;
        end else if (cap_vld) begin
            O_MAT[cap_row] <= ram_q;
        end
    end

endmodule

// File: tb/tb_bram_manager.sv
// Directed-plus-random bench for bram_manager; expectations come from a byte-array
// model of the tile store and fixed request-to-completion latencies.
module tb_bram_manager;

    localparam int NUM_MAT = 64;
    localparam int ROWS    = 16;
    localparam int COLS    = 128;
    localparam int DW      = 8;
    localparam int RD_LAT  = 18;
    localparam int WR_LAT  = 17;
    localparam int BUDGET  = 40;

    typedef logic [0:ROWS-1][0:COLS-1][DW-1:0] mat_t;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       rd_pulse = 1'b0;
    logic       wr_pulse = 1'b0;
    logic [7:0] sel      = '0;
    mat_t       mat_in   = '0;
    logic       o_vld;
    logic       o_wr_done;
    mat_t       o_mat;

    bram_manager dut (
        .I_CLK          (clk),
        .I_RST_N        (rst_n),
        .I_RD_VLD_PULSE (rd_pulse),
        .I_WR_VLD_PULSE (wr_pulse),
        .I_SEL          (sel),
        .I_MAT          (mat_in),
        .O_VLD          (o_vld),
        .O_MAT          (o_mat),
        .O_WR_DONE      (o_wr_done)
    );

    always #5 clk = ~clk;

    byte unsigned ram_model [NUM_MAT][ROWS][COLS];
    byte unsigned out_model [ROWS][COLS];
    byte unsigned pend_tile [ROWS][COLS];
    byte unsigned pat [4] = '{8'h55, 8'h66, 8'h77, 8'h88};

    int n_checks   = 0;
    int n_fail     = 0;
    int cyc        = 0;
    int accept_cyc = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_out(input string tag);
        logic [255:0] obs;
        logic [255:0] exp;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < 4; c++) begin
                for (int b = 0; b < 32; b++) begin
                    obs[255-8*b -: 8] = o_mat[r][c*32+b];
                    exp[255-8*b -: 8] = out_model[r][c*32+b];
                end
                check($sformatf("%s_row%0d_q%0d", tag, r, c), obs, exp);
            end
        end
    endtask

    // kind 0: rows cycle 0x55/0x66/0x77/0x88; kind 1: random bytes
    task automatic make_tile(input int kind);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                pend_tile[r][c] = (kind == 0) ? pat[r % 4] : 8'($urandom);
                mat_in[r][c]    = pend_tile[r][c];
            end
        end
    endtask

    task automatic scramble_bus();
        sel = 8'($urandom);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                mat_in[r][c] = 8'($urandom);
            end
        end
    endtask

    task automatic commit_rows(input int slot, input int nrows);
        for (int r = 0; r < nrows; r++) begin
            for (int c = 0; c < COLS; c++) begin
                ram_model[slot][r][c] = pend_tile[r][c];
            end
        end
    endtask

    task automatic load_out(input int slot);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                out_model[r][c] = ram_model[slot][r][c];
            end
        end
    endtask

    task automatic clear_out();
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                out_model[r][c] = 8'h00;
            end
        end
    endtask

    task automatic start_write(input logic [7:0] s);
        sel      = s;
        wr_pulse = 1'b1;
        tick();
        wr_pulse   = 1'b0;
        accept_cyc = cyc;
        scramble_bus();
    endtask

    task automatic start_read(input logic [7:0] s);
        sel      = s;
        rd_pulse = 1'b1;
        tick();
        rd_pulse   = 1'b0;
        accept_cyc = cyc;
        scramble_bus();
    endtask

    // Leaves the bench sitting in the completion-pulse cycle.
    task automatic wait_done(input bit is_read, input string tag);
        int  other = 0;
        bit  seen  = 1'b0;
        while (!seen && (cyc - accept_cyc) < BUDGET) begin
            tick();
            if (is_read ? o_vld : o_wr_done) seen = 1'b1;
            if (is_read ? o_wr_done : o_vld) other++;
        end
        check({tag, "_latency"}, cyc - accept_cyc, is_read ? RD_LAT : WR_LAT);
        check({tag, "_wrong_pulse"}, other, 0);
    endtask

    task automatic quiet(input int n, input string tag);
        int pulses = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (o_vld || o_wr_done) pulses++;
        end
        check({tag, "_quiet"}, pulses, 0);
    endtask

    task automatic do_read(input logic [7:0] s, input string tag);
        start_read(s);
        wait_done(1'b1, tag);
        load_out(int'(s) % NUM_MAT);
        check_out(tag);
        tick();
        check({tag, "_vld_width"}, o_vld, 1'b0);
    endtask

    task automatic do_write(input logic [7:0] s, input int kind, input string tag);
        make_tile(kind);
        start_write(s);
        wait_done(1'b0, tag);
        commit_rows(int'(s) % NUM_MAT, ROWS);
        tick();
        check({tag, "_done_width"}, o_wr_done, 1'b0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        tick();
        tick();
        check("reset_vld", o_vld, 1'b0);
        check("reset_wr_done", o_wr_done, 1'b0);
        clear_out();
        check_out("reset_mat");
        rst_n = 1'b1;
        tick();

        do_read(8'd0, "rd_slot0_blank");

        do_write(8'd4, 0, "wr_slot4_pattern");
        do_read(8'd4, "rd_slot4_pattern");
        do_read(8'd1, "rd_slot1_blank");

        do_write(8'd4, 1, "wr_slot4_random");
        do_read(8'd68, "rd_sel68_alias");

        // Simultaneous request: the write wins, the read is dropped.
        make_tile(1);
        sel      = 8'd20;
        wr_pulse = 1'b1;
        rd_pulse = 1'b1;
        tick();
        wr_pulse   = 1'b0;
        rd_pulse   = 1'b0;
        accept_cyc = cyc;
        scramble_bus();
        wait_done(1'b0, "both_pulses_write");
        commit_rows(20, ROWS);
        quiet(25, "both_pulses_read_dropped");
        do_read(8'd20, "rd_slot20_after_both");

        // Requests during a busy read are ignored.
        start_read(8'd4);
        tick();
        tick();
        sel      = 8'd4;
        wr_pulse = 1'b1;
        tick();
        wr_pulse = 1'b0;
        scramble_bus();
        tick();
        sel      = 8'd1;
        rd_pulse = 1'b1;
        tick();
        rd_pulse = 1'b0;
        wait_done(1'b1, "busy_read");
        load_out(4);
        check_out("busy_read");
        quiet(25, "busy_read_after");

        // Requests during a busy write are ignored.
        make_tile(1);
        start_write(8'd30);
        for (int i = 0; i < 4; i++) tick();
        sel      = 8'd31;
        wr_pulse = 1'b1;
        rd_pulse = 1'b1;
        tick();
        wr_pulse = 1'b0;
        rd_pulse = 1'b0;
        wait_done(1'b0, "busy_write");
        commit_rows(30, ROWS);
        quiet(25, "busy_write_after");
        do_read(8'd31, "rd_slot31_untouched");
        do_read(8'd30, "rd_slot30");

        // Back-to-back: a read pulsed in the O_VLD cycle is accepted.
        start_read(8'd20);
        wait_done(1'b1, "b2b_first");
        load_out(20);
        check_out("b2b_first");
        sel      = 8'd4;
        rd_pulse = 1'b1;
        tick();
        rd_pulse   = 1'b0;
        accept_cyc = cyc;
        check("b2b_vld_width", o_vld, 1'b0);
        wait_done(1'b1, "b2b_second");
        load_out(4);
        check_out("b2b_second");
        tick();

        // Reset in the middle of a read.
        start_read(8'd30);
        for (int i = 0; i < 8; i++) tick();
        rst_n = 1'b0;
        #1;
        check("rst_mid_read_vld", o_vld, 1'b0);
        check("rst_mid_read_done", o_wr_done, 1'b0);
        clear_out();
        check_out("rst_mid_read_mat");
        tick();
        rst_n = 1'b1;
        quiet(25, "rst_mid_read_no_vld");

        // Reset in the middle of a write: rows 0..5 are committed by then.
        make_tile(1);
        start_write(8'd4);
        for (int i = 0; i < 6; i++) tick();
        rst_n = 1'b0;
        #1;
        check("rst_mid_write_done", o_wr_done, 1'b0);
        tick();
        rst_n = 1'b1;
        commit_rows(4, 6);
        quiet(25, "rst_mid_write_no_done");
        do_read(8'd4, "rd_slot4_partial");
        do_read(8'd20, "rd_slot20_survives_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
